// File: rtl/tx_frame_arbiter.sv
// rtl/tx_frame_arbiter.sv - arbitrates slave reply queues and frames the winner onto the uart stream
// Frame: SYNC, ADDR, LEN, LEN payload bytes, optional XOR checksum over ADDR/LEN/payload.
module tx_frame_arbiter #(
   parameter int         N_SRC     = 25,
   parameter bit         RR_MODE   = 1'b1,
   parameter logic [7:0] SYNC_BYTE = 8'hFF,
   parameter bit         CSUM_EN   = 1'b1
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic [N_SRC-1:0]   have_msg_bus,
   input  logic [8*N_SRC-1:0] len_bus,
   input  logic [8*N_SRC-1:0] data_bus,
   output logic [N_SRC-1:0]   rdreq_bus,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               busy,
   output logic               frame_done
);
   localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   typedef enum logic [2:0] {IDLE, SYNC, ADDR, LEN, PAYLOAD, CSUM} state_t;

   state_t        state;
   logic [SW-1:0] sel;
   logic [SW-1:0] last_grant;
   logic [SW-1:0] arb_sel;
   logic [SW-1:0] arb_pos;
   logic          arb_found;
   logic [7:0]    arb_len;
   logic [7:0]    head_byte;
   logic [7:0]    cnt;
   logic [7:0]    len_r;
   logic [7:0]    csum;
   logic [7:0]    tx_byte;
   logic          accept;

   assign accept = tx_valid & tx_ready;

   // Round-robin rotates the search origin to just past the previous winner.
   always_comb begin
      arb_sel   = '0;
      arb_pos   = '0;
      arb_found = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         if (RR_MODE)
            arb_pos = SW'((int'(last_grant) + 1 + k) % N_SRC);
         else
            arb_pos = SW'(k);
         if (!arb_found && have_msg_bus[arb_pos]) begin
            arb_found = 1'b1;
            arb_sel   = arb_pos;
         end
      end
   end

   always_comb begin
      arb_len   = '0;
      head_byte = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (arb_sel == SW'(i))
            arb_len = len_bus[8*i +: 8];
         if (sel == SW'(i))
            head_byte = data_bus[8*i +: 8];
      end
   end

   always_comb begin
      rdreq_bus = '0;
      for (int i = 0; i < N_SRC; i++)
         rdreq_bus[i] = (state == PAYLOAD) && accept && (sel == SW'(i));
   end

   // Payload bytes come straight from the source head so the pop and the next byte line up.
   assign tx_data = (state == PAYLOAD) ? head_byte : tx_byte;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         sel        <= '0;
         last_grant <= SW'(N_SRC - 1);
         cnt        <= '0;
         len_r      <= '0;
         csum       <= '0;
         tx_byte    <= '0;
         tx_valid   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_found) begin
                  sel      <= arb_sel;
                  cnt      <= arb_len;
                  len_r    <= arb_len;
                  csum     <= '0;
                  busy     <= 1'b1;
                  tx_valid <= 1'b1;
                  tx_byte  <= SYNC_BYTE;
                  state    <= SYNC;
                  if (RR_MODE)
                     last_grant <= arb_sel;
               end
            end
            SYNC: begin
               if (accept) begin
                  tx_byte <= 8'(sel);
                  state   <= ADDR;
               end
            end
            ADDR: begin
               if (accept) begin
                  csum    <= csum ^ tx_data;
                  tx_byte <= len_r;
                  state   <= LEN;
               end
            end
            LEN: begin
               if (accept) begin
                  csum <= csum ^ tx_data;
                  if (len_r != 8'd0) begin
                     state <= PAYLOAD;
                  end else if (CSUM_EN) begin
                     tx_byte <= csum ^ tx_data;
                     state   <= CSUM;
                  end else begin
                     tx_byte    <= '0;
                     tx_valid   <= 1'b0;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end
               end
            end
            PAYLOAD: begin
               if (accept) begin
                  csum <= csum ^ tx_data;
                  if (cnt != 8'd1) begin
                     cnt <= cnt - 8'd1;
                  end else if (CSUM_EN) begin
                     tx_byte <= csum ^ tx_data;
                     state   <= CSUM;
                  end else begin
                     tx_byte    <= '0;
                     tx_valid   <= 1'b0;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end
               end
            end
            CSUM: begin
               if (accept) begin
                  tx_byte    <= '0;
                  tx_valid   <= 1'b0;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb/tb_tx_frame_arbiter.sv - directed vector bench for tx_frame_arbiter
`timescale 1ns/1ps
module tb_tx_frame_arbiter;
   localparam int N = 25;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           n_rst;
   logic [N-1:0]   have_msg_bus;
   logic [8*N-1:0] len_bus;
   logic [8*N-1:0] data_bus;
   logic           tx_ready;
   logic [N-1:0]   rdreq_bus, rdreq_fp, rdreq_nc;
   logic [7:0]     tx_data, tx_data_fp, tx_data_nc;
   logic           tx_valid, tx_valid_fp, tx_valid_nc;
   logic           busy, busy_fp, busy_nc;
   logic           frame_done, frame_done_fp, frame_done_nc;

   tx_frame_arbiter #(.N_SRC(N), .RR_MODE(1'b1), .SYNC_BYTE(8'hFF), .CSUM_EN(1'b1)) dut (
      .clk(clk), .n_rst(n_rst), .have_msg_bus(have_msg_bus), .len_bus(len_bus),
      .data_bus(data_bus), .rdreq_bus(rdreq_bus), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done));

   tx_frame_arbiter #(.N_SRC(N), .RR_MODE(1'b0), .SYNC_BYTE(8'hFF), .CSUM_EN(1'b1)) dut_fp (
      .clk(clk), .n_rst(n_rst), .have_msg_bus(have_msg_bus), .len_bus(len_bus),
      .data_bus(data_bus), .rdreq_bus(rdreq_fp), .tx_data(tx_data_fp), .tx_valid(tx_valid_fp),
      .tx_ready(tx_ready), .busy(busy_fp), .frame_done(frame_done_fp));

   tx_frame_arbiter #(.N_SRC(N), .RR_MODE(1'b1), .SYNC_BYTE(8'hFF), .CSUM_EN(1'b0)) dut_nc (
      .clk(clk), .n_rst(n_rst), .have_msg_bus(have_msg_bus), .len_bus(len_bus),
      .data_bus(data_bus), .rdreq_bus(rdreq_nc), .tx_data(tx_data_nc), .tx_valid(tx_valid_nc),
      .tx_ready(tx_ready), .busy(busy_nc), .frame_done(frame_done_nc));

   typedef struct {
      int          src;
      int          len;
      logic [23:0] d;
      logic [7:0]  csum;
   } vec_t;

   logic [7:0] src_mem [N][256];
   int         src_ptr [N];
   int         rdreq_cnt [N];
   logic [7:0] cap[$], cap_fp[$], cap_nc[$], exp_q[$];

   int n_checks = 0;
   int n_fail = 0;
   int tick_no, first_valid, done_tick, done_cnt, done_cnt_fp, done_cnt_nc;
   int stall_err, multi_total;
   logic       stalled;
   logic [7:0] stall_data;
   logic [N-1:0] pend;
   logic s_busy, s_busy_fp, s_busy_nc;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int cap_at(input int i);
      return (i < cap.size()) ? int'(cap[i]) : -1;
   endfunction

   function automatic int cap_fp_at(input int i);
      return (i < cap_fp.size()) ? int'(cap_fp[i]) : -1;
   endfunction

   function automatic int cap_nc_at(input int i);
      return (i < cap_nc.size()) ? int'(cap_nc[i]) : -1;
   endfunction

   task automatic drive_bus();
      for (int i = 0; i < N; i++)
         data_bus[8*i +: 8] = src_mem[i][src_ptr[i] % 256];
   endtask

   task automatic clear_stats();
      cap.delete(); cap_fp.delete(); cap_nc.delete(); exp_q.delete();
      for (int i = 0; i < N; i++) rdreq_cnt[i] = 0;
      tick_no = 0; first_valid = -1; done_tick = -1;
      done_cnt = 0; done_cnt_fp = 0; done_cnt_nc = 0;
      stall_err = 0; stalled = 1'b0; stall_data = '0;
   endtask

   // Sample mid-cycle, then pop the sources after the edge that accepted.
   task automatic tick();
      @(negedge clk);
      if (tx_valid && tx_ready) cap.push_back(tx_data);
      if (tx_valid_fp && tx_ready) cap_fp.push_back(tx_data_fp);
      if (tx_valid_nc && tx_ready) cap_nc.push_back(tx_data_nc);
      if (stalled && (!tx_valid || tx_data != stall_data)) stall_err++;
      stalled    = tx_valid && !tx_ready;
      stall_data = tx_data;
      if ($countones(rdreq_bus) > 1) multi_total++;
      if (tx_valid && first_valid < 0) first_valid = tick_no;
      if (frame_done) begin
         done_cnt++;
         if (done_tick < 0) done_tick = tick_no;
      end
      if (frame_done_fp) done_cnt_fp++;
      if (frame_done_nc) done_cnt_nc++;
      s_busy = busy; s_busy_fp = busy_fp; s_busy_nc = busy_nc;
      pend = rdreq_bus;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (pend[i]) begin
            src_ptr[i]++;
            rdreq_cnt[i]++;
         end
      drive_bus();
      tick_no++;
   endtask

   task automatic run_frame(input int s, input int len, input bit rnd, input int budget);
      len_bus[8*s +: 8] = 8'(len);
      have_msg_bus[s] = 1'b1;
      drive_bus();
      tick();
      have_msg_bus = '0;
      while (done_cnt == 0 && tick_no < budget) begin
         if (rnd) tx_ready = 1'($urandom_range(0, 1));
         tick();
      end
      tx_ready = 1'b1;
      chk("frame_done_seen", int'(done_cnt > 0), 1);
      tick();
      tick();
      chk("frame_done_single_pulse", done_cnt, 1);
      chk("busy_low_after_frame", int'(s_busy), 0);
   endtask

   task automatic check_stream(input string tag);
      chk({tag, "_nbytes"}, cap.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), cap_at(i), int'(exp_q[i]));
   endtask

   task automatic drain();
      int t;
      t = 0;
      repeat (2) tick();
      while ((s_busy || s_busy_fp || s_busy_nc) && t < 40) begin
         tick();
         t++;
      end
      chk("drain_idle", int'(s_busy | s_busy_fp | s_busy_nc), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t       vt [6];
      logic [7:0] x;
      logic [7:0] b;

      // Hand-computed: csum = ADDR ^ LEN ^ payload bytes.
      vt[0] = '{src: 4,  len: 2, d: 24'hA1A200, csum: 8'h05};
      vt[1] = '{src: 9,  len: 0, d: 24'h000000, csum: 8'h09};
      vt[2] = '{src: 0,  len: 1, d: 24'h5A0000, csum: 8'h5B};
      vt[3] = '{src: 24, len: 3, d: 24'h102030, csum: 8'h1B};
      vt[4] = '{src: 17, len: 2, d: 24'hFF0000, csum: 8'hEC};
      vt[5] = '{src: 12, len: 1, d: 24'h0C0000, csum: 8'h01};

      multi_total = 0;
      n_rst = 1'b0;
      tx_ready = 1'b1;
      have_msg_bus = '0;
      len_bus = '0;
      for (int i = 0; i < N; i++) begin
         src_ptr[i] = 0;
         for (int k = 0; k < 256; k++) src_mem[i][k] = '0;
      end
      drive_bus();
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx_valid", int'(tx_valid), 0);
      chk("reset_tx_data", int'(tx_data), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      chk("reset_rdreq", int'(rdreq_bus), 0);
      n_rst = 1'b1;

      // Round-robin vs fixed priority with sources 0, 3, 7 held.
      clear_stats();
      have_msg_bus[0] = 1'b1;
      have_msg_bus[3] = 1'b1;
      have_msg_bus[7] = 1'b1;
      while (done_cnt < 4 && tick_no < 60) tick();
      chk("rr_four_frames", int'(done_cnt >= 4), 1);
      have_msg_bus = '0;
      drain();
      chk("rr_grant0", cap_at(1), 0);
      chk("rr_grant1", cap_at(5), 3);
      chk("rr_grant2", cap_at(9), 7);
      chk("rr_grant3", cap_at(13), 0);
      chk("fp_grant0", cap_fp_at(1), 0);
      chk("fp_grant1", cap_fp_at(5), 0);
      chk("fp_grant2", cap_fp_at(9), 0);

      for (int v = 0; v < 6; v++) begin
         clear_stats();
         src_ptr[vt[v].src] = 0;
         src_mem[vt[v].src][0] = vt[v].d[23:16];
         src_mem[vt[v].src][1] = vt[v].d[15:8];
         src_mem[vt[v].src][2] = vt[v].d[7:0];
         exp_q.push_back(8'hFF);
         exp_q.push_back(8'(vt[v].src));
         exp_q.push_back(8'(vt[v].len));
         for (int k = 0; k < vt[v].len; k++) exp_q.push_back(src_mem[vt[v].src][k]);
         exp_q.push_back(vt[v].csum);
         run_frame(vt[v].src, vt[v].len, 1'b0, 60);
         check_stream($sformatf("vec%0d", v));
         chk($sformatf("vec%0d_rdreq_count", v), rdreq_cnt[vt[v].src], vt[v].len);
         chk($sformatf("vec%0d_first_valid_tick", v), first_valid, 1);
         chk($sformatf("vec%0d_done_tick", v), done_tick, 1 + exp_q.size());
         if (vt[v].len == 0) begin
            chk($sformatf("vec%0d_nocsum_nbytes", v), cap_nc.size(), 3);
            chk($sformatf("vec%0d_nocsum_b0", v), cap_nc_at(0), 8'hFF);
            chk($sformatf("vec%0d_nocsum_b1", v), cap_nc_at(1), vt[v].src);
            chk($sformatf("vec%0d_nocsum_b2", v), cap_nc_at(2), 0);
         end
      end

      // Random backpressure across a 20-byte payload.
      clear_stats();
      src_ptr[5] = 0;
      x = 8'd5 ^ 8'd20;
      exp_q.push_back(8'hFF); exp_q.push_back(8'd5); exp_q.push_back(8'd20);
      for (int k = 0; k < 20; k++) begin
         b = 8'($urandom_range(0, 255));
         src_mem[5][k] = b;
         exp_q.push_back(b);
         x = x ^ b;
      end
      exp_q.push_back(x);
      run_frame(5, 20, 1'b1, 400);
      check_stream("stall");
      chk("stall_rdreq_count", rdreq_cnt[5], 20);
      chk("stall_data_stable", stall_err, 0);

      // Maximum length frame.
      clear_stats();
      src_ptr[24] = 0;
      x = 8'd24 ^ 8'd255;
      exp_q.push_back(8'hFF); exp_q.push_back(8'd24); exp_q.push_back(8'd255);
      for (int k = 0; k < 255; k++) begin
         b = 8'((k * 37 + 11) % 256);
         src_mem[24][k] = b;
         exp_q.push_back(b);
         x = x ^ b;
      end
      exp_q.push_back(x);
      run_frame(24, 255, 1'b0, 400);
      check_stream("len255");
      chk("len255_rdreq_count", rdreq_cnt[24], 255);
      chk("len255_done_tick", done_tick, 260);

      // Asynchronous reset in the middle of a payload.
      clear_stats();
      src_ptr[2] = 0;
      for (int k = 0; k < 10; k++) src_mem[2][k] = 8'(8'h30 + k);
      len_bus[8*2 +: 8] = 8'd10;
      have_msg_bus[2] = 1'b1;
      drive_bus();
      tick();
      have_msg_bus = '0;
      while (cap.size() < 8 && tick_no < 40) tick();
      chk("rst_mid_reached_payload", cap.size(), 8);
      chk("rst_mid_pre_valid", int'(tx_valid), 1);
      n_rst = 1'b0;
      #1;
      chk("rst_mid_tx_valid", int'(tx_valid), 0);
      chk("rst_mid_tx_data", int'(tx_data), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_rdreq", int'(rdreq_bus), 0);
      chk("rst_mid_frame_done", int'(frame_done), 0);
      tick();
      n_rst = 1'b1;
      clear_stats();
      src_ptr[2] = 0;
      src_mem[2][0] = 8'h77;
      exp_q.push_back(8'hFF); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
      exp_q.push_back(8'h77); exp_q.push_back(8'h74);
      run_frame(2, 1, 1'b0, 60);
      check_stream("post_rst");

      chk("rdreq_onehot", multi_total, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
